// File: rtl/wheel_step_scheduler_if.sv
// Datapath and state-store bundle for the wheel step scheduler.
// master = scheduler side, slave = datapath / state store side.
interface wheel_step_scheduler_if #(
  parameter int NUM_WHEELS    = 2,
  parameter int NUM_NODES     = 8,
  parameter int POSITION_SIZE = 16,
  parameter int VELOCITY_SIZE = 16
) ();
  localparam int W = (NUM_WHEELS > 1) ? $clog2(NUM_WHEELS) : 1;
  localparam int N = $clog2(NUM_NODES) + 1;

  logic                            step_begin;
  logic [W-1:0]                    wheel_sel;
  logic                            node_valid_in;
  logic signed [POSITION_SIZE-1:0] node_x_in;
  logic signed [POSITION_SIZE-1:0] node_y_in;
  logic                            vel_valid_in;
  logic signed [VELOCITY_SIZE-1:0] vel_x_in;
  logic signed [VELOCITY_SIZE-1:0] vel_y_in;
  logic                            result_in;
  logic                            pos_we;
  logic [N-1:0]                    pos_idx;
  logic signed [POSITION_SIZE-1:0] pos_x;
  logic signed [POSITION_SIZE-1:0] pos_y;
  logic                            vel_we;
  logic [N-1:0]                    vel_idx;
  logic signed [VELOCITY_SIZE-1:0] vel_x;
  logic signed [VELOCITY_SIZE-1:0] vel_y;
  logic [W-1:0]                    wr_wheel;

  modport master (
    output step_begin, wheel_sel,
    output pos_we, pos_idx, pos_x, pos_y,
    output vel_we, vel_idx, vel_x, vel_y,
    output wr_wheel,
    input  node_valid_in, node_x_in, node_y_in,
    input  vel_valid_in, vel_x_in, vel_y_in,
    input  result_in
  );

  modport slave (
    input  step_begin, wheel_sel,
    input  pos_we, pos_idx, pos_x, pos_y,
    input  vel_we, vel_idx, vel_x, vel_y,
    input  wr_wheel,
    output node_valid_in, node_x_in, node_y_in,
    output vel_valid_in, vel_x_in, vel_y_in,
    output result_in
  );
endinterface

// File: rtl/wheel_step_scheduler.sv
// Time-multiplexes one wheel-update datapath across all wheels
// for SUBSTEPS updates per frame, writing results to the state store.
module wheel_step_scheduler #(
  parameter int NUM_WHEELS    = 2,
  parameter int NUM_NODES     = 8,
  parameter int POSITION_SIZE = 16,
  parameter int VELOCITY_SIZE = 16,
  parameter int SUBSTEPS      = 4,
  parameter int TIMEOUT       = 4095,
  localparam int S = $clog2(SUBSTEPS) + 1
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         frame_tick,
  input  logic         err_clr,
  wheel_step_scheduler_if.master bus,
  output logic [S-1:0] substep,
  output logic         busy,
  output logic         frame_done,
  output logic         timeout_err,
  output logic         count_err,
  output logic         overrun_err
);
  localparam int W = (NUM_WHEELS > 1) ? $clog2(NUM_WHEELS) : 1;
  localparam int N = $clog2(NUM_NODES) + 1;
  localparam int D = $clog2(TIMEOUT + 1);

  localparam logic [N-1:0] NN = N'(NUM_NODES);
  localparam logic [D-1:0] TO = D'(TIMEOUT);
  localparam logic [W-1:0] LW = W'(NUM_WHEELS - 1);
  localparam logic [S-1:0] LS = S'(SUBSTEPS - 1);

  localparam int I_IDLE   = 0;
  localparam int I_LAUNCH = 1;
  localparam int I_WAIT   = 2;
  localparam int I_NEXT   = 3;
  localparam int I_DONE   = 4;

  localparam logic [4:0] ST_IDLE   = 5'b00001;
  localparam logic [4:0] ST_LAUNCH = 5'b00010;
  localparam logic [4:0] ST_WAIT   = 5'b00100;
  localparam logic [4:0] ST_NEXT   = 5'b01000;
  localparam logic [4:0] ST_DONE   = 5'b10000;

  logic [4:0]   state, state_n;
  logic [N-1:0] pcnt, vcnt;
  logic [N-1:0] pcnt_eff, vcnt_eff;
  logic [D-1:0] wd;
  logic [W-1:0] wsel;
  logic         pos_ok, vel_ok;
  logic         wd_hit, last_w, last_s;
  logic         t_set, c_set, o_set;

  assign pos_ok   = state[I_WAIT] & bus.node_valid_in
                  & (pcnt < NN);
  assign vel_ok   = state[I_WAIT] & bus.vel_valid_in
                  & (vcnt < NN);
  assign pcnt_eff = pcnt + N'(pos_ok);
  assign vcnt_eff = vcnt + N'(vel_ok);
  assign wd_hit   = (wd == TO);
  assign last_w   = (wsel == LW);
  assign last_s   = (substep == LS);

  // A result in the same cycle as a timeout still completes the step.
  assign t_set = state[I_WAIT] & ~bus.result_in & wd_hit;
  assign c_set = state[I_WAIT] & (
      (bus.node_valid_in & ~(pcnt < NN))
    | (bus.vel_valid_in & ~(vcnt < NN))
    | (bus.result_in & ((pcnt_eff != NN) | (vcnt_eff != NN))));
  assign o_set = frame_tick & ~state[I_IDLE];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      state[I_IDLE]:
        if (frame_tick) state_n = ST_LAUNCH;
      state[I_LAUNCH]:
        state_n = ST_WAIT;
      state[I_WAIT]:
        if (bus.result_in) state_n = ST_NEXT;
        else if (wd_hit)   state_n = ST_DONE;
      state[I_NEXT]:
        if (last_w && last_s) state_n = ST_DONE;
        else                  state_n = ST_LAUNCH;
      state[I_DONE]:
        state_n = ST_IDLE;
      default:
        state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.step_begin = state[I_LAUNCH];
    bus.wheel_sel  = wsel;
    busy           = ~state[I_IDLE];
    frame_done     = state[I_DONE];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wsel         <= '0;
      substep      <= '0;
      pcnt         <= '0;
      vcnt         <= '0;
      wd           <= '0;
      bus.pos_we   <= 1'b0;
      bus.pos_idx  <= '0;
      bus.pos_x    <= '0;
      bus.pos_y    <= '0;
      bus.vel_we   <= 1'b0;
      bus.vel_idx  <= '0;
      bus.vel_x    <= '0;
      bus.vel_y    <= '0;
      bus.wr_wheel <= '0;
      timeout_err  <= 1'b0;
      count_err    <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      bus.pos_we <= pos_ok;
      bus.vel_we <= vel_ok;
      if (state[I_IDLE] && frame_tick) begin
        wsel    <= '0;
        substep <= '0;
      end
      if (state[I_LAUNCH]) begin
        pcnt <= '0;
        vcnt <= '0;
        wd   <= '0;
      end
      if (state[I_WAIT] && !wd_hit) wd <= wd + D'(1);
      if (pos_ok) begin
        bus.pos_idx <= pcnt;
        bus.pos_x   <= POSITION_SIZE'(bus.node_x_in);
        bus.pos_y   <= POSITION_SIZE'(bus.node_y_in);
        pcnt        <= pcnt + N'(1);
      end
      if (vel_ok) begin
        bus.vel_idx <= vcnt;
        bus.vel_x   <= VELOCITY_SIZE'(bus.vel_x_in);
        bus.vel_y   <= VELOCITY_SIZE'(bus.vel_y_in);
        vcnt        <= vcnt + N'(1);
      end
      if (pos_ok || vel_ok) bus.wr_wheel <= wsel;
      if (state[I_NEXT]) begin
        if (!last_w) begin
          wsel <= wsel + W'(1);
        end else if (!last_s) begin
          wsel    <= '0;
          substep <= substep + S'(1);
        end
      end
      timeout_err <= t_set | (timeout_err & ~err_clr);
      count_err   <= c_set | (count_err & ~err_clr);
      overrun_err <= o_set | (overrun_err & ~err_clr);
    end
  end
endmodule

// File: tb/tb_wheel_step_scheduler.sv
// Directed bench for wheel_step_scheduler with a write scoreboard.
// Expected store writes are queued as beats are driven.
module tb_wheel_step_scheduler;
  localparam int NW = 2;
  localparam int NN = 4;
  localparam int SS = 2;
  localparam int TO = 64;
  localparam int PS = 16;
  localparam int VS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       err_clr = 1'b0;
  logic [1:0] substep;
  logic       busy, frame_done;
  logic       timeout_err, count_err, overrun_err;

  wheel_step_scheduler_if #(
    .NUM_WHEELS(NW), .NUM_NODES(NN),
    .POSITION_SIZE(PS), .VELOCITY_SIZE(VS)
  ) bus ();

  wheel_step_scheduler #(
    .NUM_WHEELS(NW), .NUM_NODES(NN),
    .POSITION_SIZE(PS), .VELOCITY_SIZE(VS),
    .SUBSTEPS(SS), .TIMEOUT(TO)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .frame_tick(frame_tick),
    .err_clr(err_clr),
    .bus(bus.master),
    .substep(substep),
    .busy(busy),
    .frame_done(frame_done),
    .timeout_err(timeout_err),
    .count_err(count_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [35:0] pq[$];
  logic [35:0] vq[$];
  int n_pos, n_vel, n_sb, e_pos, e_vel;
  int exp_w, exp_s;
  logic exp_t, exp_c, exp_o;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.step_begin) n_sb++;
      if (bus.pos_we) begin
        n_pos++;
        chk("pos_q_nonempty", 64'(pq.size() != 0), 1);
        if (pq.size() != 0)
          chk("pos_wr", {bus.pos_idx, bus.pos_x,
              bus.pos_y, bus.wr_wheel}, pq.pop_front());
      end
      if (bus.vel_we) begin
        n_vel++;
        chk("vel_q_nonempty", 64'(vq.size() != 0), 1);
        if (vq.size() != 0)
          chk("vel_wr", {bus.vel_idx, bus.vel_x,
              bus.vel_y, bus.wr_wheel}, vq.pop_front());
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_pos"}, {bus.pos_we, bus.pos_idx,
        bus.pos_x, bus.pos_y, bus.wr_wheel}, 0);
    chk({tag, "_vel"}, {bus.vel_we, bus.vel_idx,
        bus.vel_x, bus.vel_y}, 0);
    chk({tag, "_ctl"}, {bus.step_begin, bus.wheel_sel,
        substep, busy, frame_done, timeout_err,
        count_err, overrun_err}, 0);
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    exp_w = 0; exp_s = 0;
    n_sb = 0; n_pos = 0; n_vel = 0;
    e_pos = 0; e_vel = 0;
  endtask

  task automatic wait_sb(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      frame_tick = 1'b0;
      err_clr = 1'b0;
      waited++;
    end while (!bus.step_begin && waited < 20);
  endtask

  task automatic step(input int np, input int nv,
                      input bit tog, input bit coinc);
    int waited, last, r, pc, vc;
    logic [15:0] a, b;
    pc = 0; vc = 0;
    wait_sb(waited);
    chk("sb_latency", 64'(waited), 1);
    chk("wheel_sel", 64'(bus.wheel_sel), 64'(exp_w));
    chk("substep", 64'(substep), 64'(exp_s));
    last = tog ? ((np > nv) ? np : nv) - 1 : np + nv - 1;
    r = coinc ? last : ((last + 1 > 9) ? last + 1 : 9);
    for (int c = 0; c <= r; c++) begin
      @(negedge clk);
      bus.node_valid_in = 1'b0;
      bus.vel_valid_in  = 1'b0;
      bus.result_in     = (c == r);
      if (c < np) begin
        a = 16'($urandom); b = 16'($urandom);
        bus.node_valid_in = 1'b1;
        bus.node_x_in = a; bus.node_y_in = b;
        if (pc < NN) begin
          pq.push_back({3'(pc), a, b, 1'(exp_w)});
          e_pos++;
        end
        pc++;
      end
      if (tog ? (c < nv) : (c >= np && c < np + nv)) begin
        a = 16'($urandom); b = 16'($urandom);
        bus.vel_valid_in = 1'b1;
        bus.vel_x_in = a; bus.vel_y_in = b;
        if (vc < NN) begin
          vq.push_back({3'(vc), a, b, 1'(exp_w)});
          e_vel++;
        end
        vc++;
      end
    end
    @(negedge clk);
    bus.node_valid_in = 1'b0;
    bus.vel_valid_in  = 1'b0;
    bus.result_in     = 1'b0;
    if (np != NN || nv != NN) exp_c = 1'b1;
    if (exp_w < NW - 1) exp_w++;
    else begin exp_w = 0; exp_s++; end
  endtask

  task automatic frame_end();
    chk("fd_early", 64'(frame_done), 0);
    @(negedge clk);
    chk("frame_done", 64'(frame_done), 1);
    chk("busy_done", 64'(busy), 1);
    @(negedge clk);
    chk("busy_idle", 64'(busy), 0);
    chk("fd_pulse", 64'(frame_done), 0);
    chk("timeout_err", 64'(timeout_err), 64'(exp_t));
    chk("count_err", 64'(count_err), 64'(exp_c));
    chk("overrun_err", 64'(overrun_err), 64'(exp_o));
    chk("sb_count", 64'(n_sb), 64'(NW * SS));
    chk("pos_count", 64'(n_pos), 64'(e_pos));
    chk("vel_count", 64'(n_vel), 64'(e_vel));
    chk("q_drained", 64'(pq.size() + vq.size()), 0);
  endtask

  task automatic clear_errs();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_t = 1'b0; exp_c = 1'b0; exp_o = 1'b0;
    chk("err_clr", {timeout_err, count_err,
        overrun_err}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int k;
    bus.node_valid_in = 1'b0;
    bus.node_x_in = '0; bus.node_y_in = '0;
    bus.vel_valid_in = 1'b0;
    bus.vel_x_in = '0; bus.vel_y_in = '0;
    bus.result_in = 1'b0;
    exp_t = 1'b0; exp_c = 1'b0; exp_o = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    tick();
    for (int i = 0; i < 4; i++) step(4, 4, 0, 0);
    frame_end();

    tick();
    step(4, 4, 1, 0);
    step(4, 4, 1, 1);
    step(4, 4, 1, 1);
    step(4, 4, 1, 0);
    frame_end();

    tick();
    step(3, 4, 1, 0);
    step(5, 4, 1, 0);
    step(4, 4, 1, 0);
    step(4, 4, 1, 0);
    frame_end();
    clear_errs();

    tick();
    step(4, 4, 1, 0);
    frame_tick = 1'b1;
    err_clr = 1'b1;
    exp_o = 1'b1;
    for (int i = 0; i < 3; i++) step(4, 4, 1, 0);
    frame_end();
    clear_errs();

    tick();
    wait_sb(k);
    chk("to_sb", 64'(bus.step_begin), 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_done && k < 100);
    chk("to_latency", 64'(k), 66);
    chk("to_flag", 64'(timeout_err), 1);
    chk("to_busy", 64'(busy), 1);
    @(negedge clk);
    chk("to_idle", 64'(busy), 0);
    clear_errs();

    tick();
    step(4, 4, 1, 0);
    wait_sb(k);
    chk("rst_pre_wsel", 64'(bus.wheel_sel), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    pq.delete(); vq.delete();
    exp_t = 1'b0; exp_c = 1'b0; exp_o = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) step(4, 4, 1, 0);
    frame_end();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
